// File: rtl/gpio_irq_if.sv
// Peripheral-bus and pad-ring bundle for gpio_irq.
// The core/bench side uses master, the peripheral uses slave.
interface gpio_irq_if #(
    parameter int NUM_IO = 16
);
    logic              we;
    logic [31:0]       wraddr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [NUM_IO-1:0] gpio_in;
    logic [NUM_IO-1:0] gpio_out;
    logic [NUM_IO-1:0] gpio_oe;
    logic              irq;

    modport master (
        output we, wraddr, wdata, gpio_in,
        input  rdata, gpio_out, gpio_oe, irq
    );

    modport slave (
        input  we, wraddr, wdata, gpio_in,
        output rdata, gpio_out, gpio_oe, irq
    );
endinterface

// File: rtl/gpio_irq.sv
// NUM_IO-pin GPIO with per-pin mode, atomic set/clear, synchronised inputs
// and per-pin edge interrupts with a write-1-to-clear status register.
module gpio_irq #(
    parameter int NUM_IO      = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    gpio_irq_if.slave  bus
);
    localparam logic [4:0] A_CTRL  = 5'h00;
    localparam logic [4:0] A_DOUT  = 5'h04;
    localparam logic [4:0] A_DIN   = 5'h08;
    localparam logic [4:0] A_SET   = 5'h0C;
    localparam logic [4:0] A_CLR   = 5'h10;
    localparam logic [4:0] A_IEN   = 5'h14;
    localparam logic [4:0] A_ITYPE = 5'h18;
    localparam logic [4:0] A_ISTAT = 5'h1C;

    logic [2*NUM_IO-1:0] ctrl_q, ctrl_d;
    logic [NUM_IO-1:0]   dout_q, dout_d;
    logic [NUM_IO-1:0]   ien_q, ien_d;
    logic [NUM_IO-1:0]   itype_q, itype_d;
    logic [NUM_IO-1:0]   istat_q, istat_d;
    logic [NUM_IO-1:0]   prev_q;
    logic [NUM_IO-1:0]   sync_q [SYNC_STAGES];

    logic [NUM_IO-1:0]   pin_out, pin_in, sync_last, edge_det, wd;
    logic [4:0]          addr;
    logic [31:0]         rdata_c;
    logic                unused_bits;

    assign addr        = bus.wraddr[4:0];
    assign wd          = bus.wdata[NUM_IO-1:0];
    assign sync_last   = sync_q[SYNC_STAGES-1];
    assign unused_bits = ^{bus.wraddr[31:5], bus.wdata};

    // Mode 11 falls through both compares and behaves as high-Z.
    always_comb begin
        pin_out = '0;
        pin_in  = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            pin_out[i] = (ctrl_q[2*i +: 2] == 2'b01);
            pin_in[i]  = (ctrl_q[2*i +: 2] == 2'b10);
        end
    end

    assign edge_det = pin_in & ((~itype_q & sync_last & ~prev_q) |
                                ( itype_q & ~sync_last & prev_q));

    always_comb begin
        ctrl_d  = ctrl_q;
        dout_d  = dout_q;
        ien_d   = ien_q;
        itype_d = itype_q;
        istat_d = istat_q;
        if (bus.we) begin
            case (addr)
                A_CTRL:  ctrl_d  = bus.wdata[2*NUM_IO-1:0];
                A_DOUT:  dout_d  = wd;
                A_SET:   dout_d  = dout_q | wd;
                A_CLR:   dout_d  = dout_q & ~wd;
                A_IEN:   ien_d   = wd;
                A_ITYPE: itype_d = wd;
                A_ISTAT: istat_d = istat_q & ~wd;
                default: ;
            endcase
        end
        // A fresh edge overrides a same-cycle clear.
        istat_d = istat_d | edge_det;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= '0;
            dout_q  <= '0;
            ien_q   <= '0;
            itype_q <= '0;
            istat_q <= '0;
            prev_q  <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            dout_q  <= dout_d;
            ien_q   <= ien_d;
            itype_q <= itype_d;
            istat_q <= istat_d;
            prev_q  <= sync_last;
            sync_q[0] <= bus.gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        rdata_c = '0;
        if (rst) begin
            case (addr)
                A_CTRL:  rdata_c = 32'(ctrl_q);
                A_DOUT:  rdata_c = 32'(dout_q);
                A_DIN:   rdata_c = 32'(sync_last);
                A_IEN:   rdata_c = 32'(ien_q);
                A_ITYPE: rdata_c = 32'(itype_q);
                A_ISTAT: rdata_c = 32'(istat_q);
                default: rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.gpio_out = dout_q;
    assign bus.gpio_oe  = pin_out;
    assign bus.irq      = |(istat_q & ien_q);
endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: a per-pin behavioural model predicts every
// cycle's read data and pad outputs, a monitor compares at the falling edge.
module tb_gpio_irq;
    localparam int N = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpio_irq_if #(.NUM_IO(N)) bus_if ();

    gpio_irq #(.NUM_IO(N), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic [N-1:0] out;
        logic [N-1:0] oe;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    bit   chk_pending = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: per-pin register arrays plus the history of pad
    // samples taken at each clock edge (index 0 = most recent).
    bit [1:0]   m_mode [N];
    bit         m_out  [N];
    bit         m_en   [N];
    bit         m_type [N];
    bit         m_stat [N];
    bit [N-1:0] hist   [S+1];

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 2'b00; m_out[i] = 0; m_en[i] = 0; m_type[i] = 0; m_stat[i] = 0;
        end
        for (int j = 0; j <= S; j++) hist[j] = '0;
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a, bit rst_v);
        logic [31:0] r = '0;
        if (!rst_v) return '0;
        for (int i = 0; i < N; i++) begin
            case (a)
                5'h00: r[2*i +: 2] = m_mode[i];
                5'h04: r[i] = m_out[i];
                5'h08: r[i] = hist[S-1][i];
                5'h14: r[i] = m_en[i];
                5'h18: r[i] = m_type[i];
                5'h1C: r[i] = m_stat[i];
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic void m_clock(bit rst_v, bit we_v, logic [31:0] a, logic [31:0] d,
                                    logic [N-1:0] gin);
        bit ev [N];
        if (!rst_v) begin
            m_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            bit now_v = hist[S-1][i];
            bit old_v = hist[S][i];
            ev[i] = (m_mode[i] == 2'b10) &&
                    (m_type[i] ? (!now_v && old_v) : (now_v && !old_v));
        end
        if (we_v) begin
            for (int i = 0; i < N; i++) begin
                case (a[4:0])
                    5'h00: m_mode[i] = d[2*i +: 2];
                    5'h04: m_out[i]  = d[i];
                    5'h0C: if (d[i]) m_out[i] = 1;
                    5'h10: if (d[i]) m_out[i] = 0;
                    5'h14: m_en[i]   = d[i];
                    5'h18: m_type[i] = d[i];
                    5'h1C: if (d[i]) m_stat[i] = 0;
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < N; i++) if (ev[i]) m_stat[i] = 1;
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = gin;
    endfunction

    function automatic exp_t m_predict(string nm, logic [31:0] a, bit rst_v);
        exp_t e;
        e.nm  = nm;
        e.rd  = m_read(a[4:0], rst_v);
        e.irq = 0;
        for (int i = 0; i < N; i++) begin
            e.out[i] = m_out[i];
            e.oe[i]  = (m_mode[i] == 2'b01);
            if (m_stat[i] && m_en[i]) e.irq = 1;
        end
        return e;
    endfunction

    task automatic check_val(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_pending) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got 0 entries expected 1");
                end else begin
                    e = sb_q.pop_front();
                    check_val({e.nm, " rdata"},    bus_if.rdata,            e.rd);
                    check_val({e.nm, " gpio_out"}, 32'(bus_if.gpio_out),    32'(e.out));
                    check_val({e.nm, " gpio_oe"},  32'(bus_if.gpio_oe),     32'(e.oe));
                    check_val({e.nm, " irq"},      32'(bus_if.irq),         32'(e.irq));
                end
            end
        end
    end

    logic [N-1:0] gin = '0;

    // Inputs change 1 time unit after the rising edge; the model advances
    // with the same values once the edge has passed.
    task automatic cycle(bit rst_v, bit we_v, logic [31:0] a, logic [31:0] d, bit chk,
                         string nm);
        rst           = rst_v;
        bus_if.we     = we_v;
        bus_if.wraddr = a;
        bus_if.wdata  = d;
        bus_if.gpio_in = gin;
        if (chk) sb_q.push_back(m_predict(nm, a, rst_v));
        chk_pending = chk;
        @(posedge clk);
        m_clock(rst_v, we_v, a, d, gin);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, string nm);
        cycle(1'b1, 1'b1, a, d, 1'b1, nm);
    endtask

    task automatic rd(logic [31:0] a, string nm);
        cycle(1'b1, 1'b0, a, 32'h0, 1'b1, nm);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] a, d;
        bus_if.we = 0; bus_if.wraddr = '0; bus_if.wdata = '0; bus_if.gpio_in = '0;
        m_reset();
        #1;
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "reset0");
        cycle(1'b0, 1'b1, 32'h4, 32'hF, 1'b1, "reset1");
        cycle(1'b0, 1'b0, 32'h1C, 32'h0, 1'b1, "reset2");
        for (int k = 0; k < 8; k++) rd(32'(k * 4), "map_after_reset");

        wr(32'h00, 32'hFFFF_FFFF, "ctrl_all_ones");
        rd(32'h00, "ctrl_masked");

        wr(32'h00, 32'h0000_0005, "ctrl_out01");
        wr(32'h04, 32'h1, "dout_write");
        wr(32'h0C, 32'h2, "set_write");
        rd(32'h04, "dout_after_set");
        rd(32'h0C, "set_reads_zero");
        wr(32'h10, 32'h1, "clr_write");
        rd(32'h04, "dout_after_clr");
        rd(32'h10, "clr_reads_zero");

        wr(32'h00, 32'h0000_0025, "ctrl_pin2_in");
        wr(32'h14, 32'h4, "ien_pin2");
        wr(32'h18, 32'h0, "type_rising");
        gin[2] = 1'b1;
        rd(32'h08, "rise_k");
        rd(32'h08, "rise_k1");
        rd(32'h1C, "rise_k2");
        rd(32'h1C, "rise_k3");
        wr(32'h1C, 32'h4, "w1c_pin2");
        rd(32'h1C, "after_w1c");

        wr(32'h18, 32'h8, "type_pin3_fall");
        gin[3] = 1'b1;
        for (int k = 0; k < 4; k++) rd(32'h1C, "pin3_rise_ignored");
        wr(32'h00, 32'h0000_00A5, "ctrl_pin3_in");
        gin[3] = 1'b0;
        for (int k = 0; k < 4; k++) rd(32'h1C, "pin3_fall_masked");
        wr(32'h14, 32'hC, "ien_pin3");
        rd(32'h1C, "pin3_irq_enabled");
        wr(32'h1C, 32'h8, "w1c_pin3");
        for (int k = 0; k < 6; k++) begin
            gin[0] = ~gin[0];
            rd(32'h1C, "pin0_output_gated");
        end

        gin[2] = 1'b0;
        for (int k = 0; k < 4; k++) rd(32'h1C, "pin2_low");
        gin[2] = 1'b1;
        rd(32'h1C, "simul_c0");
        rd(32'h1C, "simul_c1");
        wr(32'h1C, 32'h4, "simul_w1c_vs_edge");
        rd(32'h1C, "simul_status");
        rd(32'h1C, "simul_status2");

        gin = '0;
        cycle(1'b0, 1'b0, 32'h1C, 32'h0, 1'b1, "midop_reset");
        for (int k = 0; k < 8; k++) rd(32'(k * 4), "map_after_midop_reset");
        for (int k = 0; k < 4; k++) rd(32'h1C, "no_false_edge");

        for (int k = 0; k < 500; k++) begin
            if (k % 3 == 0) gin = N'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[4:0] = 5'(4 * $urandom_range(0, 7));
            d = $urandom;
            if ($urandom_range(0, 99) == 0)
                cycle(1'b0, 1'b0, a, d, 1'b1, "rand_reset");
            else
                cycle(1'b1, 1'($urandom_range(0, 1)), a, d, 1'b1, "rand");
        end

        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "drain");
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
Parametrised successor to the 2-pin GPIO peripheral: NUM_IO pins with per-pin mode, atomic set/clear of output bits, synchronised inputs, and per-pin edge-triggered interrupts with a write-1-to-clear status register. Sits on the core's peripheral bus with the same write-enable/address/data and combinational read interface. Drives the pad ring through separate out/oe vectors and raises one level interrupt to the core.

Parameters:
NUM_IO, 16, number of pins; legal range 1..16 (2 CTRL bits per pin in a 32-bit register).
SYNC_STAGES, 2, input synchroniser depth; legal minimum 2.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
we  input  1  write strobe, one write per cycle
wraddr  input  32  register address; only wraddr[4:0] decoded
wdata  input  32  write data
rdata  output  32  combinational read data for wraddr
gpio_in  input  NUM_IO  asynchronous pad inputs
gpio_out  output  NUM_IO  pad output values (= DATA_OUT)
gpio_oe  output  NUM_IO  pad output enables; bit i = 1 iff CTRL pin i mode is 01
irq  output  1  level interrupt, |(IRQ_STATUS & IRQ_EN)

Behaviour:
- Reset (rst=0 at posedge): every register, synchroniser stage and edge-history flop clears to 0. gpio_out=0, gpio_oe=0, irq=0. rdata=0 combinationally while rst=0. Reset mid-operation discards pending edges and status.
- Register map (wraddr[4:0]); bits at or above NUM_IO (2*NUM_IO for CTRL) read 0 and ignore writes:
  0x00 CTRL rw: 2 bits per pin; 00 high-Z, 01 output, 10 input, 11 treated as high-Z.
  0x04 DATA_OUT rw.
  0x08 DATA_IN ro: last synchroniser stage.
  0x0C SET wo: DATA_OUT |= wdata; reads 0.
  0x10 CLR wo: DATA_OUT &= ~wdata; reads 0.
  0x14 IRQ_EN rw.
  0x18 IRQ_TYPE rw: per pin, 0 = rising edge, 1 = falling edge.
  0x1C IRQ_STATUS rw1c: writing 1 clears that bit; writing 0 has no effect.
  Other offsets: reads 0, writes ignored.
- Writes take effect at the posedge where we=1. Register value and gpio_out/gpio_oe update one cycle after the write cycle.
- Synchroniser: gpio_in passes through SYNC_STAGES flops every cycle, regardless of mode. prev holds the last stage delayed one cycle.
- Edge on pin i: sync_last[i]=1 and prev[i]=0 (rising) or sync_last[i]=0 and prev[i]=1 (falling), selected by IRQ_TYPE[i]. Detection is gated by CTRL pin i mode == 10. Edges on pins in other modes are ignored, and no status is recorded for them.
- Latency: when a pin change is first captured by stage 1 at posedge k, DATA_IN reflects it after posedge k+SYNC_STAGES-1 and IRQ_STATUS sets at posedge k+SYNC_STAGES. irq follows combinationally.
- Status is set regardless of IRQ_EN; IRQ_EN only masks irq. Enabling a pin whose status bit is already set raises irq immediately.
- A detected edge and a W1C on the same bit in the same cycle: the edge wins and the bit stays 1.
- Switching a pin to input mode does not create a spurious edge, because the synchroniser has been tracking the pin continuously.
- No input-data writeback into DATA_OUT. Input values are visible only via DATA_IN.

Test Plan:
- Reset/map: hold rst=0 for 3 cycles, release, read all 8 offsets -> all 0, gpio_oe=0, irq=0. Write CTRL=0xFFFFFFFF with NUM_IO=4 -> CTRL reads 0x000000FF.
- Output and atomic ops: CTRL=0x00000005 (pins 0,1 out), DATA_OUT=0x1, SET=0x2 -> gpio_out=0x3, gpio_oe=0x3. CLR=0x1 -> gpio_out=0x2. SET and CLR offsets read 0.
- Rising IRQ: CTRL pin 2=10, IRQ_EN=0x4, IRQ_TYPE=0. Drive gpio_in[2] 0->1 just before posedge k -> DATA_IN[2]=1 after k+1, IRQ_STATUS=0x4 and irq=1 after k+2. Write 0x1C=0x4 -> irq=0.
- Falling, mask and mode gating: pin 3 IRQ_TYPE=1, IRQ_EN=0, toggle 1->0 -> STATUS bit 3 set, irq=0. Set IRQ_EN bit 3 -> irq=1 next cycle. Pin 0 in output mode with an input toggle -> no status bit.
- Simultaneous: W1C of bit 2 issued in the same cycle a new rising edge is detected on pin 2 -> STATUS bit 2 remains 1, irq stays 1.
- Reset mid-op: STATUS=0x4, irq=1, pulse rst=0 for 1 cycle -> all registers 0, irq=0. No false edge after release with gpio_in held at 0.
